// File: rtl/spi_master_param_if.sv
// -----------------------------------------------------------------------------
// spi_master_param_if
// Control-side bus of the parametrised SPI master: transfer request, the
// per-transfer configuration latched on an accepted start, and the status /
// result returned by the master.
//   master modport : register/control block (drives start and configuration)
//   slave  modport : spi_master_param (returns busy, done, data_out)
// Signals:
//   start    transfer request, accepted only while busy=0
//   data_in  word to transmit
//   ss_sel   slave index
//   cpol     SCLK idle level (also drives idle sclk live)
//   cpha     clock phase
//   clk_div  half-period = clk_div+1 clk cycles
//   busy     transfer in progress
//   done     one-cycle end-of-transfer pulse
//   data_out received word, valid from done until the next done
// -----------------------------------------------------------------------------
interface spi_master_param_if #(
  parameter int DATA_W   = 8,
  parameter int SS_SEL_W = 1,
  parameter int DIV_W    = 8
);
  logic                start;
  logic [DATA_W-1:0]   data_in;
  logic [SS_SEL_W-1:0] ss_sel;
  logic                cpol;
  logic                cpha;
  logic [DIV_W-1:0]    clk_div;
  logic                busy;
  logic                done;
  logic [DATA_W-1:0]   data_out;

  modport master (
    output start, data_in, ss_sel, cpol, cpha, clk_div,
    input  busy, done, data_out
  );

  modport slave (
    input  start, data_in, ss_sel, cpol, cpha, clk_div,
    output busy, done, data_out
  );
endinterface

// File: rtl/spi_master_param.sv
// -----------------------------------------------------------------------------
// spi_master_param
// Parametrised full-duplex SPI master. One accepted start runs exactly one
// DATA_W-bit transfer in any of the four CPOL/CPHA modes, with a runtime SCLK
// half-period of clk_div+1 clk cycles and NUM_SS active-low slave selects.
// Transfer phases: LEAD (ss_n asserted, H cycles), XFER (2*DATA_W half-periods,
// one SCLK edge at the start of each), TRAIL (H cycles), then done.
// Ports:
//   clk       system clock (posedge)
//   rst       synchronous active-high reset, aborts any transfer
//   lsb_first (only with SPI_MASTER_LSB_FIRST_EN) LSB-first order, latched on start
//   bus       control bus, slave modport of spi_master_param_if
//   miso      serial data from slave
//   sclk      SPI clock
//   mosi      serial data to slave
//   ss_n      active-low slave selects
// Optional feature macro: SPI_MASTER_LSB_FIRST_EN (adds lsb_first port).
// -----------------------------------------------------------------------------
module spi_master_param #(
  parameter int DATA_W   = 8,
  parameter int NUM_SS   = 1,
  parameter int SS_SEL_W = 1,
  parameter int DIV_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
`ifdef SPI_MASTER_LSB_FIRST_EN
  input  logic              lsb_first,
`endif
  spi_master_param_if.slave bus,
  input  logic              miso,
  output logic              sclk,
  output logic              mosi,
  output logic [NUM_SS-1:0] ss_n
);

  localparam int EW = $clog2(2 * DATA_W + 1);
  localparam logic [EW-1:0] EDGE_ALL  = EW'(2 * DATA_W);
  localparam logic [EW-1:0] EDGE_LAST = EW'(2 * DATA_W - 1);

  typedef enum logic [1:0] {S_IDLE, S_LEAD, S_XFER, S_TRAIL} state_t;

  state_t              r_state;
  logic [DIV_W:0]      r_cnt;      // one extra bit so LEAD can start at -1
  logic [DIV_W-1:0]    r_div;
  logic [EW-1:0]       r_edge;     // SCLK edges produced so far
  logic [DATA_W-1:0]   r_tx;
  logic [DATA_W-1:0]   r_rx;
  logic [SS_SEL_W-1:0] r_ss_sel;
  logic                r_cpol;
  logic                r_cpha;
  logic                r_sclk;
  logic                r_mosi;
  logic [NUM_SS-1:0]   r_ss_n;
  logic                r_busy;
  logic                r_done;
  logic [DATA_W-1:0]   r_data_out;

  logic                w_tick;
  logic [NUM_SS-1:0]   w_ss_dec;
  logic [DATA_W-1:0]   w_tx_load;
  logic [DATA_W-1:0]   w_rx_word;

  // End of a half-period (or of the LEAD/TRAIL phase).
  assign w_tick = (r_cnt == {1'b0, r_div});

  // Out-of-range ss_sel matches no line, so no slave is selected.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_SS; gi++) begin : g_ss_dec
      assign w_ss_dec[gi] = (r_ss_sel == SS_SEL_W'(gi)) ? 1'b0 : 1'b1;
    end
  endgenerate

`ifdef SPI_MASTER_LSB_FIRST_EN
  // LSB-first is handled by bit-reversing on load and on result, so the
  // shift datapath itself is always MSB-first.
  logic              r_lsb;
  logic [DATA_W-1:0] w_din_rev;
  logic [DATA_W-1:0] w_rx_rev;
  generate
    for (gi = 0; gi < DATA_W; gi++) begin : g_rev
      assign w_din_rev[gi] = bus.data_in[DATA_W-1-gi];
      assign w_rx_rev[gi]  = r_rx[DATA_W-1-gi];
    end
  endgenerate
  assign w_tx_load = lsb_first ? w_din_rev : bus.data_in;
  assign w_rx_word = r_lsb ? w_rx_rev : r_rx;
`else
  assign w_tx_load = bus.data_in;
  assign w_rx_word = r_rx;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_div      <= '0;
      r_edge     <= '0;
      r_tx       <= '0;
      r_rx       <= '0;
      r_ss_sel   <= '0;
      r_cpol     <= 1'b0;
      r_cpha     <= 1'b0;
      r_sclk     <= 1'b0;
      r_mosi     <= 1'b0;
      r_ss_n     <= '1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_data_out <= '0;
`ifdef SPI_MASTER_LSB_FIRST_EN
      r_lsb      <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_sclk <= bus.cpol;
          r_ss_n <= '1;
          if (bus.start) begin
            r_tx     <= w_tx_load;
            r_rx     <= '0;
            r_ss_sel <= bus.ss_sel;
            r_cpol   <= bus.cpol;
            r_cpha   <= bus.cpha;
            r_div    <= bus.clk_div;
            // Preload -1: the first LEAD cycle only asserts ss_n, so LEAD
            // then spans exactly H cycles with ss_n low before the first edge.
            r_cnt    <= '1;
            r_edge   <= '0;
            r_busy   <= 1'b1;
            r_state  <= S_LEAD;
`ifdef SPI_MASTER_LSB_FIRST_EN
            r_lsb    <= lsb_first;
`endif
          end
        end

        S_LEAD: begin
          r_ss_n <= w_ss_dec;
          r_sclk <= r_cpol;
          if (!r_cpha) r_mosi <= r_tx[DATA_W-1];
          if (w_tick) begin
            // First (leading) SCLK edge.
            r_cnt   <= '0;
            r_sclk  <= ~r_cpol;
            r_edge  <= EW'(1);
            r_state <= S_XFER;
            if (r_cpha) begin
              r_mosi <= r_tx[DATA_W-1];
              r_tx   <= r_tx << 1;
            end else begin
              r_rx <= {r_rx[DATA_W-2:0], miso};
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_XFER: begin
          if (w_tick) begin
            r_cnt <= '0;
            if (r_edge == EDGE_ALL) begin
              // Last half-period after the final edge has elapsed.
              r_state <= S_TRAIL;
            end else begin
              r_sclk <= ~r_sclk;
              r_edge <= r_edge + 1'b1;
              if (r_edge[0]) begin
                // Trailing edge.
                if (r_cpha) begin
                  r_rx <= {r_rx[DATA_W-2:0], miso};
                end else if (r_edge != EDGE_LAST) begin
                  r_mosi <= r_tx[DATA_W-2];
                  r_tx   <= r_tx << 1;
                end
              end else begin
                // Leading edge.
                if (r_cpha) begin
                  r_mosi <= r_tx[DATA_W-1];
                  r_tx   <= r_tx << 1;
                end else begin
                  r_rx <= {r_rx[DATA_W-2:0], miso};
                end
              end
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_TRAIL: begin
          r_sclk <= r_cpol;
          if (w_tick) begin
            r_cnt      <= '0;
            r_ss_n     <= '1;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            r_data_out <= w_rx_word;
            r_state    <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign sclk         = r_sclk;
  assign mosi         = r_mosi;
  assign ss_n         = r_ss_n;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.data_out = r_data_out;

endmodule

// File: tb/tb_spi_master_param.sv
// -----------------------------------------------------------------------------
// tb_spi_master_param
// Directed bench for spi_master_param (DATA_W=8, NUM_SS=4, SS_SEL_W=3).
// Stimulus pushes the expected word and latency into a scoreboard queue; a
// monitor pops and compares whenever done pulses.
// -----------------------------------------------------------------------------
module tb_spi_master_param;
  localparam int DATA_W   = 8;
  localparam int NUM_SS   = 4;
  localparam int SS_SEL_W = 3;
  localparam int DIV_W    = 8;

  logic              clk;
  logic              rst;
  logic              miso;
  logic              sclk;
  logic              mosi;
  logic [NUM_SS-1:0] ss_n;
  logic              lsb_first;
  logic              loop_en;
  logic              miso_val;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [7:0] data;
    int         start_cyc;
    int         lat;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  spi_master_param_if #(.DATA_W(DATA_W), .SS_SEL_W(SS_SEL_W), .DIV_W(DIV_W)) bus_if ();

  spi_master_param #(
    .DATA_W(DATA_W), .NUM_SS(NUM_SS), .SS_SEL_W(SS_SEL_W), .DIV_W(DIV_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
`ifdef SPI_MASTER_LSB_FIRST_EN
    .lsb_first(lsb_first),
`endif
    .bus      (bus_if.slave),
    .miso     (miso),
    .sclk     (sclk),
    .mosi     (mosi),
    .ss_n     (ss_n)
  );

  assign miso = loop_en ? mosi : miso_val;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int lat_of(input logic [7:0] div);
    return (2 * DATA_W + 2) * (int'(div) + 1) + 1;
  endfunction

  // Scoreboard monitor: one line per completed transfer.
  always @(negedge clk) begin
    if (!rst && bus_if.done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=%0h required=no_done", bus_if.data_out);
      end else begin
        mon_e = sb.pop_front();
        $display("XFER data_out=%02h expected=%02h latency=%0d expected=%0d",
                 bus_if.data_out, mon_e.data, cyc - mon_e.start_cyc, mon_e.lat);
        check("data_out", 32'(bus_if.data_out), 32'(mon_e.data));
        check("latency", 32'(cyc - mon_e.start_cyc), 32'(mon_e.lat));
      end
    end
  end

  // Called at a negedge; returns at the negedge after the start edge.
  task automatic issue_start(input logic [7:0] din, input logic [2:0] sel,
                             input logic pol, input logic pha, input logic [7:0] div,
                             input logic lp, input logic mv, input logic lsb,
                             input logic [7:0] exp);
    exp_t e;
    bus_if.data_in = din;
    bus_if.ss_sel  = sel;
    bus_if.cpol    = pol;
    bus_if.cpha    = pha;
    bus_if.clk_div = div;
    loop_en        = lp;
    miso_val       = mv;
    lsb_first      = lsb;
    bus_if.start   = 1'b1;
    e.data      = exp;
    e.start_cyc = cyc + 1;
    e.lat       = lat_of(div);
    sb.push_back(e);
    @(negedge clk);
    bus_if.start = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc);
    bit seen = 0;
    for (int k = 0; k < max_cyc && !seen; k++) begin
      if (bus_if.done) seen = 1;
      else @(negedge clk);
    end
    if (!seen) check("done_timeout", 32'd0, 32'd1);
  endtask

  // Runs one transfer and observes it; returns at the negedge where done is seen.
  task automatic run_xfer(input logic [7:0] din, input logic [2:0] sel,
                          input logic pol, input logic pha, input logic [7:0] div,
                          input logic lp, input logic mv, input logic lsb,
                          input logic [7:0] exp, input int poke_at,
                          output int ss_low, output logic [3:0] ss_and,
                          output logic [15:0] bits, output int nbits, output int hp);
    logic prev_sclk;
    int   first_e, second_e;
    bit   seen;
    issue_start(din, sel, pol, pha, div, lp, mv, lsb, exp);
    ss_low = 0; ss_and = '1; bits = '0; nbits = 0; hp = 0;
    first_e = -1; second_e = -1; seen = 0;
    prev_sclk = sclk;
    for (int k = 0; k < 4000 && !seen; k++) begin
      if (bus_if.done) begin
        seen = 1;
      end else begin
        if (ss_n != 4'hF) ss_low++;
        ss_and &= ss_n;
        if (sclk != prev_sclk) begin
          if (first_e < 0) first_e = k;
          else if (second_e < 0) second_e = k;
          if (sclk) begin
            bits = {bits[14:0], mosi};
            nbits++;
          end
        end
        prev_sclk = sclk;
        if (k == poke_at) begin
          bus_if.start   = 1'b1;
          bus_if.data_in = 8'h00;
        end else if (bus_if.start) begin
          bus_if.start = 1'b0;
        end
        @(negedge clk);
      end
    end
    if (!seen) check("xfer_timeout", 32'd0, 32'd1);
    hp = second_e - first_e;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  int          ss_low, nbits, hp, tog;
  logic [3:0]  ss_and;
  logic [15:0] bits;
  logic        prev;

  initial begin
    rst = 1'b1;
    bus_if.start = 1'b0; bus_if.data_in = '0; bus_if.ss_sel = '0;
    bus_if.cpol = 1'b0; bus_if.cpha = 1'b0; bus_if.clk_div = '0;
    loop_en = 1'b0; miso_val = 1'b0; lsb_first = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_sclk", 32'(sclk), 32'd0);
    check("rst_mosi", 32'(mosi), 32'd0);
    check("rst_ss_n", 32'(ss_n), 32'hF);
    check("rst_busy", 32'(bus_if.busy), 32'd0);
    check("rst_done", 32'(bus_if.done), 32'd0);
    check("rst_data_out", 32'(bus_if.data_out), 32'd0);
    rst = 1'b0;

    // Idle sclk follows live cpol
    bus_if.cpol = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_sclk_cpol1", 32'(sclk), 32'd1);
    bus_if.cpol = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_sclk_cpol0", 32'(sclk), 32'd0);

    // Mode 0, clk_div=0, loopback 0xA5
    run_xfer(8'hA5, 3'd0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 8'hA5, -1,
             ss_low, ss_and, bits, nbits, hp);
    check("m0_mosi_bits", 32'(bits[7:0]), 32'hA5);
    check("m0_nbits", 32'(nbits), 32'd8);
    check("m0_ss_low", 32'(ss_low), 32'd18);
    check("m0_ss_and", 32'(ss_and), 32'hE);
    @(negedge clk);

    // Mode 3, clk_div=2, miso=1
    bus_if.cpol = 1'b1;
    repeat (2) @(negedge clk);
    check("m3_idle_sclk", 32'(sclk), 32'd1);
    run_xfer(8'h3C, 3'd0, 1'b1, 1'b1, 8'd2, 1'b0, 1'b1, 1'b0, 8'hFF, -1,
             ss_low, ss_and, bits, nbits, hp);
    check("m3_half_period", 32'(hp), 32'd3);
    check("m3_ss_low", 32'(ss_low), 32'd54);
    @(negedge clk);

    // ss_sel=2: only ss_n[2] low
    run_xfer(8'h96, 3'd2, 1'b0, 1'b0, 8'd1, 1'b0, 1'b0, 1'b0, 8'h00, -1,
             ss_low, ss_and, bits, nbits, hp);
    check("sel2_ss_and", 32'(ss_and), 32'hB);
    check("sel2_ss_low", 32'(ss_low), 32'd36);
    @(negedge clk);

    // ss_sel=5: no line asserted, done still pulses
    run_xfer(8'h5A, 3'd5, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 8'hFF, -1,
             ss_low, ss_and, bits, nbits, hp);
    check("sel5_ss_and", 32'(ss_and), 32'hF);
    check("sel5_ss_low", 32'(ss_low), 32'd0);
    @(negedge clk);

    // Start poked mid-transfer with data_in=0 is ignored
    run_xfer(8'hC6, 3'd1, 1'b0, 1'b0, 8'd1, 1'b1, 1'b0, 1'b0, 8'hC6, 10,
             ss_low, ss_and, bits, nbits, hp);
    check("ign_mosi_bits", 32'(bits[7:0]), 32'hC6);
    check("ign_ss_and", 32'(ss_and), 32'hD);
    // Back-to-back start in the done cycle, mode 2 loopback
    issue_start(8'h81, 3'd0, 1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 8'h81);
    check("b2b_busy", 32'(bus_if.busy), 32'd1);
    wait_done(100);
    repeat (60) @(negedge clk);
    check("b2b_idle_busy", 32'(bus_if.busy), 32'd0);

    // Reset at the 5th sclk edge aborts the transfer
    issue_start(8'h5A, 3'd0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 8'h5A);
    tog = 0;
    prev = sclk;
    for (int k = 0; k < 200 && tog < 5; k++) begin
      @(negedge clk);
      if (sclk != prev) tog++;
      prev = sclk;
    end
    check("abort_edges", 32'(tog), 32'd5);
    sb.delete();
    rst = 1'b1;
    @(negedge clk);
    check("abort_sclk", 32'(sclk), 32'd0);
    check("abort_ss_n", 32'(ss_n), 32'hF);
    check("abort_busy", 32'(bus_if.busy), 32'd0);
    check("abort_done", 32'(bus_if.done), 32'd0);
    check("abort_data_out", 32'(bus_if.data_out), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Clean mode 1 transfer after the abort
    run_xfer(8'h6E, 3'd3, 1'b0, 1'b1, 8'd0, 1'b1, 1'b0, 1'b0, 8'h6E, -1,
             ss_low, ss_and, bits, nbits, hp);
    check("post_ss_low", 32'(ss_low), 32'd18);
    check("post_ss_and", 32'(ss_and), 32'h7);
    @(negedge clk);

`ifdef SPI_MASTER_LSB_FIRST_EN
    // LSB first: first mosi bit is data_in[0]
    run_xfer(8'h01, 3'd0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 8'h01, -1,
             ss_low, ss_and, bits, nbits, hp);
    check("lsb_first_bit", 32'(bits[7]), 32'd1);
    check("lsb_mosi_bits", 32'(bits[7:0]), 32'h80);
    @(negedge clk);
`endif

    repeat (5) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
